// File: rtl/strength_resolver_pipe.sv
// strength_resolver_pipe: two-stage clocked multi-driver net resolver with contention counter
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid            driver vector valid this cycle
//   drv_en/val/s1/s0    per-driver enable, value and strength codes (packed per driver)
//   cnt_clr             clears contention counter and sticky flag
//   out_valid           result valid (2 cycles after in_valid)
//   res_val/res_zx      4-state result per bit: {zx,val} 00=0 01=1 10=z 11=x
//   res_str             winning strength per bit (3 bits each)
//   cont_cnt/cont_seen  saturating x-result counter and sticky x flag
module strength_resolver_pipe #(
  parameter int NDRV  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [NDRV-1:0]      drv_en,
  input  logic [NDRV*WIDTH-1:0] drv_val,
  input  logic [NDRV*3-1:0]    drv_s1,
  input  logic [NDRV*3-1:0]    drv_s0,
  input  logic                 cnt_clr,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     res_val,
  output logic [WIDTH-1:0]     res_zx,
  output logic [WIDTH*3-1:0]   res_str,
  output logic [CNT_W-1:0]     cont_cnt,
  output logic                 cont_seen
);
  logic [WIDTH-1:0][2:0] m1_d, m0_d, m1_q, m0_q, str_d, str_q;
  logic [WIDTH-1:0]      val_d, zx_d;
  logic                  v1;
  logic                  any_x;

  // codes 5..7 are treated as supply
  function automatic logic [2:0] clamp(input logic [2:0] s);
    return (s > 3'd4) ? 3'd4 : s;
  endfunction

  // a strength of 0 never raises the max, so it contributes nothing
  always_comb begin
    m1_d = '0;
    m0_d = '0;
    for (int b = 0; b < WIDTH; b++)
      for (int d = 0; d < NDRV; d++)
        if (drv_en[d]) begin
          if (drv_val[d*WIDTH+b]) begin
            if (clamp(drv_s1[d*3 +: 3]) > m1_d[b]) m1_d[b] = clamp(drv_s1[d*3 +: 3]);
          end else begin
            if (clamp(drv_s0[d*3 +: 3]) > m0_d[b]) m0_d[b] = clamp(drv_s0[d*3 +: 3]);
          end
        end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      m1_q <= '0;
      m0_q <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        m1_q <= m1_d;
        m0_q <= m0_d;
      end
    end
  end

  // ties resolve by net type: wand/wor pick a side, tri0/tri1 pull an undriven net
  always_comb begin
    val_d = '0;
    zx_d  = '0;
    str_d = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (m1_q[b] > m0_q[b]) begin
        {zx_d[b], val_d[b], str_d[b]} = {2'b01, m1_q[b]};
      end else if (m0_q[b] > m1_q[b]) begin
        {zx_d[b], val_d[b], str_d[b]} = {2'b00, m0_q[b]};
      end else if (m1_q[b] != 3'd0) begin
        {zx_d[b], val_d[b]} = (MODE == 1) ? 2'b00 : (MODE == 2) ? 2'b01 : 2'b11;
        str_d[b] = m1_q[b];
      end else begin
        {zx_d[b], val_d[b]} = (MODE == 3) ? 2'b00 : (MODE == 4) ? 2'b01 : 2'b10;
        str_d[b] = (MODE == 3 || MODE == 4) ? 3'd2 : 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_val   <= '0;
      res_zx    <= '1;
      str_q     <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        res_val <= val_d;
        res_zx  <= zx_d;
        str_q   <= str_d;
      end
    end
  end

  assign res_str = str_q;
  assign any_x   = |(res_zx & res_val);

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      cont_cnt  <= '0;
      cont_seen <= 1'b0;
    end else if (out_valid && any_x) begin
      cont_seen <= 1'b1;
      if (cont_cnt != {CNT_W{1'b1}}) cont_cnt <= cont_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_strength_resolver_pipe.sv
// tb_strength_resolver_pipe: directed checks of strength_resolver_pipe across all net modes
module tb_strength_resolver_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, cnt_clr;
  logic [1:0]  drv_en;
  logic [15:0] drv_val;
  logic [5:0]  drv_s1, drv_s0;
  logic        ov [5];
  logic [7:0]  rv [5];
  logic [7:0]  rzx [5];
  logic [23:0] rs [5];
  logic [15:0] cc [5];
  logic        cs [5];
  logic        sov, scs;
  logic [7:0]  srv, szx;
  logic [23:0] srs;
  logic [2:0]  scc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_mode
    strength_resolver_pipe #(.NDRV(2), .WIDTH(8), .MODE(g), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .drv_en(drv_en), .drv_val(drv_val),
      .drv_s1(drv_s1), .drv_s0(drv_s0), .cnt_clr(cnt_clr), .out_valid(ov[g]), .res_val(rv[g]),
      .res_zx(rzx[g]), .res_str(rs[g]), .cont_cnt(cc[g]), .cont_seen(cs[g]));
  end

  strength_resolver_pipe #(.NDRV(2), .WIDTH(8), .MODE(0), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .drv_en(drv_en), .drv_val(drv_val),
    .drv_s1(drv_s1), .drv_s0(drv_s0), .cnt_clr(cnt_clr), .out_valid(sov), .res_val(srv),
    .res_zx(szx), .res_str(srs), .cont_cnt(scc), .cont_seen(scs));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en0, en1, input logic [7:0] v0, v1,
                       input logic [2:0] a1, a0, b1, b0);
    drv_en  = {en1, en0};
    drv_val = {v1, v0};
    drv_s1  = {b1, a1};
    drv_s0  = {b0, a0};
  endtask

  task automatic pulse;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  function automatic logic [40:0] obs(input int m);
    return {ov[m], rzx[m], rv[m], rs[m]};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int m = 0; m < 5; m++) begin
      checks++;
      if ({obs(m), cc[m], cs[m]} !== {1'b0, 8'hFF, 8'h00, 24'h0, 16'h0, 1'b0}) begin
        errors++;
        $display("FAIL reset_mode%0d: got %h want %h", m, {obs(m), cc[m], cs[m]},
                 {1'b0, 8'hFF, 8'h00, 24'h0, 16'h0, 1'b0});
      end
    end
    checks++;
    if ({sov, szx, srv, srs, scc, scs} !== {1'b0, 8'hFF, 8'h00, 24'h0, 3'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_sat: got %h", {sov, szx, srv, srs, scc, scs});
    end
  endtask

  task automatic test_basic;
    drive(1, 1, 8'hFF, 8'h00, 4, 4, 3, 3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL basic_latency1: got %b want 0", ov[0]); end
    tick();
    checks++;
    if (obs(0) !== {1'b1, 8'h00, 8'hFF, {8{3'd4}}}) begin
      errors++; $display("FAIL basic_res: got %h want %h", obs(0), {1'b1, 8'h00, 8'hFF, {8{3'd4}}});
    end
    drive(1, 1, 8'h00, 8'h00, 2, 2, 2, 2);
    tick();
    checks++;
    if ({obs(0), cc[0]} !== {1'b0, 8'h00, 8'hFF, {8{3'd4}}, 16'd0}) begin
      errors++; $display("FAIL basic_hold: got %h", {obs(0), cc[0]});
    end
  endtask

  task automatic test_equal;
    logic [40:0] exp_r [3];
    exp_r[0] = {1'b1, 8'hFF, 8'hFF, {8{3'd2}}};
    exp_r[1] = {1'b1, 8'h00, 8'h00, {8{3'd2}}};
    exp_r[2] = {1'b1, 8'h00, 8'hFF, {8{3'd2}}};
    drive(1, 1, 8'hFF, 8'h00, 2, 2, 2, 2);
    pulse();
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (obs(m) !== exp_r[m]) begin
        errors++; $display("FAIL equal_mode%0d: got %h want %h", m, obs(m), exp_r[m]);
      end
    end
    tick();
    checks++;
    if ({cc[0], cs[0]} !== {16'd1, 1'b1}) begin
      errors++; $display("FAIL equal_cnt_tri: got %0d/%b want 1/1", cc[0], cs[0]);
    end
    checks++;
    if ({cc[1], cs[1], cc[2], cs[2]} !== 34'd0) begin
      errors++; $display("FAIL equal_cnt_wandwor: got %0d/%b %0d/%b want 0", cc[1], cs[1], cc[2], cs[2]);
    end
  endtask

  task automatic test_undriven;
    logic [40:0] exp_r [5];
    exp_r[0] = {1'b1, 8'hFF, 8'h00, 24'h0};
    exp_r[1] = exp_r[0];
    exp_r[2] = exp_r[0];
    exp_r[3] = {1'b1, 8'h00, 8'h00, {8{3'd2}}};
    exp_r[4] = {1'b1, 8'h00, 8'hFF, {8{3'd2}}};
    drive(0, 0, 8'hFF, 8'h00, 4, 4, 4, 4);
    pulse();
    for (int m = 0; m < 5; m++) begin
      checks++;
      if (obs(m) !== exp_r[m]) begin
        errors++; $display("FAIL undriven_mode%0d: got %h want %h", m, obs(m), exp_r[m]);
      end
    end
    drive(1, 1, 8'hFF, 8'h00, 0, 3, 3, 0);
    pulse();
    checks++;
    if (obs(0) !== exp_r[0]) begin
      errors++; $display("FAIL highz_sides: got %h want %h", obs(0), exp_r[0]);
    end
    drive(1, 1, 8'hFF, 8'h00, 7, 0, 0, 4);
    pulse();
    checks++;
    if (obs(0) !== {1'b1, 8'hFF, 8'hFF, {8{3'd4}}}) begin
      errors++; $display("FAIL clamp: got %h want %h", obs(0), {1'b1, 8'hFF, 8'hFF, {8{3'd4}}});
    end
    drive(1, 0, 8'h0F, 8'h00, 3, 1, 0, 0);
    pulse();
    checks++;
    if (obs(0) !== {1'b1, 8'h00, 8'h0F, {4{3'd1}}, {4{3'd3}}}) begin
      errors++; $display("FAIL mixed_bits: got %h want %h", obs(0), {1'b1, 8'h00, 8'h0F, {4{3'd1}}, {4{3'd3}}});
    end
  endtask

  task automatic test_back_to_back;
    logic [40:0] e;
    int a, b;
    tick();
    for (int i = 0; i < 26; i++) begin
      if (i < 25) begin
        drive(1, 1, 8'hFF, 8'h00, 3'(i / 5), 0, 0, 3'(i % 5));
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      tick();
      if (i == 0) begin
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL sweep_latency: got %b want 0", ov[0]); end
      end else begin
        a = (i - 1) / 5;
        b = (i - 1) % 5;
        if (a > b)       e = {1'b1, 8'h00, 8'hFF, {8{3'(a)}}};
        else if (b > a)  e = {1'b1, 8'h00, 8'h00, {8{3'(b)}}};
        else if (a != 0) e = {1'b1, 8'hFF, 8'hFF, {8{3'(a)}}};
        else             e = {1'b1, 8'hFF, 8'h00, 24'h0};
        checks++;
        if (obs(0) !== e) begin
          errors++; $display("FAIL sweep_s1_%0d_s0_%0d: got %h want %h", a, b, obs(0), e);
        end
      end
    end
  endtask

  task automatic test_saturate;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if ({scc, scs} !== 4'd0) begin errors++; $display("FAIL sat_clear: got %0d/%b want 0/0", scc, scs); end
    drive(1, 1, 8'hFF, 8'h00, 2, 2, 2, 2);
    in_valid = 1'b1;
    repeat (9) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({scc, scs} !== {3'd7, 1'b1}) begin errors++; $display("FAIL sat_cnt: got %0d/%b want 7/1", scc, scs); end
    in_valid = 1'b1;
    tick(); tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({sov, scc, scs} !== {1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL clr_priority: got ov=%b cnt=%0d seen=%b want 1/0/0", sov, scc, scs);
    end
    repeat (3) tick();
    checks++;
    if ({scc, scs} !== {3'd2, 1'b1}) begin errors++; $display("FAIL clr_resume: got %0d/%b want 2/1", scc, scs); end
  endtask

  task automatic test_reset_flight;
    drive(1, 1, 8'hFF, 8'h00, 4, 4, 3, 3);
    in_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL flight_valid%0d: got %b want 0", k, ov[0]); end
      tick();
    end
    checks++;
    if ({obs(0), cc[0], cs[0]} !== {1'b0, 8'hFF, 8'h00, 24'h0, 16'h0, 1'b0}) begin
      errors++; $display("FAIL flight_state: got %h", {obs(0), cc[0], cs[0]});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_undriven();
    test_back_to_back();
    test_saturate();
    test_reset_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
